// File: rtl/calc_pkg.sv
// Shared codes for the calculator entry path: key op codes, display selects, FSM states.
package calc_pkg;

  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_EQ  = 4'd14;

  localparam logic [1:0] DISP_A   = 2'd0;
  localparam logic [1:0] DISP_B   = 2'd1;
  localparam logic [1:0] DISP_RES = 2'd2;
  localparam logic [1:0] DISP_ERR = 2'd3;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  function automatic logic is_arith_op(input logic [3:0] code);
    return (code >= OP_MUL) && (code <= OP_DIV);
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Turns the decoder's click levels into a single-cycle key event with its code and kind.
module key_event_detect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_digit,
  input  logic       new_op,
  input  logic [3:0] key_code,
  output logic       key_evt,
  output logic       key_is_op,
  output logic [3:0] key_val
);

  logic lvl, lvl_q;

  assign lvl = new_digit | new_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= 1'b0;
    else        lvl_q <= lvl;
  end

  // Only the rising edge counts, so a held click (and any code wobble under it) is one event.
  assign key_evt   = lvl & ~lvl_q;
  assign key_is_op = ~new_digit;
  assign key_val   = key_code;

endmodule

// File: rtl/calc_entry_sequencer.sv
// Calculator entry FSM: builds operands A/B, runs one ALU transaction per '=', holds the result.
// Optional CALC_CHAIN_RESULT_EN: an op key in SHOW continues from the result as new operand A.
module calc_entry_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_digit,
  input  logic             new_op,
  input  logic [3:0]       key_code,
  output logic             alu_start,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] disp_value,
  output logic [1:0]       disp_sel,
  output logic             busy,
  output logic             err
);

  localparam int              CW   = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0]   MAXD = CW'(MAX_DIGITS);

  logic             key_evt, key_is_op;
  logic [3:0]       key_val;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, disp_q, disp_d;
  logic [CW-1:0]    na_q, na_d, nb_q, nb_d;
  logic [3:0]       op_q, op_d;
  logic [1:0]       sel_q, sel_d;
  logic             err_q, err_d, start_q, start_d;

  key_event_detect u_key (
    .clk       (clk),
    .rst_n     (rst_n),
    .new_digit (new_digit),
    .new_op    (new_op),
    .key_code  (key_code),
    .key_evt   (key_evt),
    .key_is_op (key_is_op),
    .key_val   (key_val)
  );

  function automatic logic [WIDTH-1:0] acc(input logic [WIDTH-1:0] v, input logic [3:0] d);
    return v * WIDTH'(10) + WIDTH'(d);
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    na_d    = na_q;
    nb_d    = nb_q;
    op_d    = op_q;
    err_d   = err_q;
    start_d = 1'b0;
    disp_d  = disp_q;
    sel_d   = sel_q;

    case (state_q)
      ENTER_A: begin
        if (key_evt && !key_is_op) begin
          if (na_q < MAXD) begin
            a_d  = acc(a_q, key_val);
            na_d = na_q + CW'(1);
          end
        end else if (key_evt && is_arith_op(key_val)) begin
          op_d    = key_val;
          b_d     = '0;
          nb_d    = '0;
          state_d = ENTER_B;
        end
      end
      ENTER_B: begin
        if (key_evt && !key_is_op) begin
          if (nb_q < MAXD) begin
            b_d  = acc(b_q, key_val);
            nb_d = nb_q + CW'(1);
          end
        end else if (key_evt && is_arith_op(key_val)) begin
          if (nb_q == '0) op_d = key_val;
        end else if (key_evt && key_val == OP_EQ && nb_q != '0) begin
          if (op_q == OP_DIV && b_q == '0) begin
            err_d   = 1'b1;
            state_d = SHOW;
          end else begin
            start_d = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (alu_done) begin
          r_d     = alu_result;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (key_evt && !key_is_op) begin
          a_d     = WIDTH'(key_val);
          na_d    = CW'(1);
          b_d     = '0;
          nb_d    = '0;
          err_d   = 1'b0;
          state_d = ENTER_A;
        end
`ifdef CALC_CHAIN_RESULT_EN
        else if (key_evt && is_arith_op(key_val)) begin
          // Result becomes A; digit count is saturated so A cannot be extended.
          a_d     = r_q;
          na_d    = MAXD;
          op_d    = key_val;
          b_d     = '0;
          nb_d    = '0;
          err_d   = 1'b0;
          state_d = ENTER_B;
        end
`endif
      end
      default: state_d = ENTER_A;
    endcase

    // Display is computed from next-state values so it moves together with the operands.
    case (state_d)
      ENTER_B: begin
        if (nb_d != '0) begin
          disp_d = b_d;
          sel_d  = DISP_B;
        end else begin
          disp_d = a_d;
          sel_d  = DISP_A;
        end
      end
      SHOW: begin
        disp_d = r_d;
        sel_d  = err_d ? DISP_ERR : DISP_RES;
      end
      default: begin
        disp_d = a_d;
        sel_d  = DISP_A;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      na_q    <= '0;
      nb_q    <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      disp_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      op_q    <= op_d;
      err_q   <= err_d;
      start_q <= start_d;
      disp_q  <= disp_d;
      sel_q   <= sel_d;
    end
  end

  assign alu_start  = start_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign disp_value = disp_q;
  assign disp_sel   = sel_q;
  assign busy       = (state_q == CALC);
  assign err        = err_q;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Directed bench for calc_entry_sequencer: clicks keys, plays the ALU, checks hand-computed values.
module tb_calc_entry_sequencer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             new_digit = 1'b0, new_op = 1'b0;
  logic [3:0]       key_code = '0;
  logic             alu_start;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_op;
  logic             alu_done = 1'b0;
  logic [WIDTH-1:0] alu_result = '0;
  logic [WIDTH-1:0] disp_value;
  logic [1:0]       disp_sel;
  logic             busy, err;

  int n_cmp = 0, n_bad = 0;
  int n_start = 0;
  logic [WIDTH-1:0] cap_a = '0, cap_b = '0;
  logic [3:0]       cap_op = '0;

  calc_entry_sequencer #(.WIDTH(WIDTH), .MAX_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .new_digit(new_digit), .new_op(new_op), .key_code(key_code),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result),
    .disp_value(disp_value), .disp_sel(disp_sel), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (alu_start) begin
      n_start <= n_start + 1;
      cap_a   <= alu_a;
      cap_b   <= alu_b;
      cap_op  <= alu_op;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic click(input logic is_op, input logic [3:0] code);
    @(negedge clk);
    new_digit = ~is_op;
    new_op    = is_op;
    key_code  = code;
    repeat (2) @(negedge clk);
    new_digit = 1'b0;
    new_op    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    new_digit = 1'b0; new_op = 1'b0; alu_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic alu_reply(input logic [WIDTH-1:0] v);
    repeat (5) @(negedge clk);
    alu_result = v;
    alu_done   = 1'b1;
    @(negedge clk);
    alu_done   = 1'b0;
    @(negedge clk);
  endtask

  // '=' press with exact start-pulse timing checks.
  task automatic press_eq_expect_start(input string tag);
    @(negedge clk);
    new_op = 1'b1; key_code = 4'd14;
    @(posedge clk); #1;
    chk({tag, "_start_lat"}, alu_start, 1);
    @(posedge clk); #1;
    chk({tag, "_start_pulse"}, alu_start, 0);
    @(negedge clk);
    new_op = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_test1(input string tag, input int starts_before);
    click(0, 1); click(0, 2);
    chk({tag, "_dispA"}, disp_value, 12);
    click(1, 2); click(0, 3); click(0, 4);
    chk({tag, "_dispB"}, disp_value, 34);
    chk({tag, "_selB"}, disp_sel, 1);
    press_eq_expect_start(tag);
    chk({tag, "_nstart"}, n_start, starts_before + 1);
    chk({tag, "_a"}, cap_a, 12);
    chk({tag, "_b"}, cap_b, 34);
    chk({tag, "_op"}, cap_op, 2);
    chk({tag, "_busy"}, busy, 1);
    alu_reply(46);
    chk({tag, "_res"}, disp_value, 46);
    chk({tag, "_sel_res"}, disp_sel, 2);
    chk({tag, "_busy_off"}, busy, 0);
  endtask

  initial begin
    int s0;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_disp", disp_value, 0);
    chk("rst_sel", disp_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_op", alu_op, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 12 + 34 = 46
    run_test1("t1", 0);

    // 2: held digit 7 from SHOW, code wobbles while held
    @(negedge clk);
    new_digit = 1'b1; key_code = 4'd7;
    @(posedge clk); #1;
    chk("t2_lat", disp_value, 7);
    repeat (20) @(negedge clk);
    key_code = 4'd3;
    repeat (30) @(negedge clk);
    new_digit = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_A", disp_value, 7);
    chk("t2_sel", disp_sel, 0);
    chk("t2_alu_a", alu_a, 7);

    // 3: digit limit
    do_reset();
    repeat (4) click(0, 9);
    chk("t3_4dig", disp_value, 9999);
    repeat (2) click(0, 9);
    chk("t3_6dig", disp_value, 9999);

    // 4: divide by zero
    do_reset();
    s0 = n_start;
    click(0, 8); click(1, 4); click(0, 0);
    chk("t4_selB0", disp_sel, 1);
    chk("t4_B0", disp_value, 0);
    click(1, 14);
    chk("t4_err", err, 1);
    chk("t4_sel_err", disp_sel, 3);
    chk("t4_nostart", n_start, s0);
    chk("t4_busy", busy, 0);
    click(0, 5);
    chk("t4_err_clr", err, 0);
    chk("t4_A5", disp_value, 5);
    chk("t4_selA", disp_sel, 0);

    // 5: op replacement and bare '='
    do_reset();
    s0 = n_start;
    click(0, 5); click(1, 2); click(1, 3);
    chk("t5_op_repl", alu_op, 3);
    click(1, 14);
    chk("t5_eq_noB", n_start, s0);
    chk("t5_sel_noB", disp_sel, 0);
    chk("t5_disp_noB", disp_value, 5);
    click(0, 2);
    press_eq_expect_start("t5");
    chk("t5_a", cap_a, 5);
    chk("t5_b", cap_b, 2);
    chk("t5_op", cap_op, 3);
    alu_reply(3);
    chk("t5_res", disp_value, 3);

    // 6: keys during CALC, reset mid-CALC, late done
    do_reset();
    click(0, 1); click(0, 2); click(1, 2); click(0, 3); click(0, 4);
    click(1, 14);
    chk("t6_busy", busy, 1);
    click(0, 9); click(1, 1);
    chk("t6_hold_a", alu_a, 12);
    chk("t6_hold_b", alu_b, 34);
    chk("t6_hold_op", alu_op, 2);
    chk("t6_still_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_a", alu_a, 0);
    chk("t6_rst_b", alu_b, 0);
    chk("t6_rst_op", alu_op, 0);
    chk("t6_rst_disp", disp_value, 0);
    chk("t6_rst_sel", disp_sel, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    alu_result = 16'd777; alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    @(negedge clk);
    chk("t6_late_busy", busy, 0);
    chk("t6_late_sel", disp_sel, 0);
    chk("t6_late_disp", disp_value, 0);

    s0 = n_start;
    run_test1("t6r", s0);
    s0 = n_start;
    click(1, 2); click(0, 1); click(1, 14);
`ifdef CALC_CHAIN_RESULT_EN
    chk("t6_chain_start", n_start, s0 + 1);
    chk("t6_chain_a", cap_a, 46);
    chk("t6_chain_b", cap_b, 1);
    chk("t6_chain_op", cap_op, 2);
`else
    chk("t6_nochain_start", n_start, s0);
    chk("t6_nochain_disp", disp_value, 1);
    chk("t6_nochain_sel", disp_sel, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
